// File: rtl/decode_mac_pkg.sv
// Shared definitions for the decode/MAC pipeline: op encoding, the tag that
// rides alongside the data, and the saturation limit helpers.
package decode_mac_pkg;

  // Widest accumulator the saturation helpers can describe.
  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MAC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_RSVD = 2'b11   // behaves exactly like OP_MUL
  } op_e;

  // Control that travels with each sample through the pipeline.
  typedef struct packed {
    logic valid;
    op_e  op;
  } tag_t;

  // Largest signed value representable in w bits, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Smallest signed value in w bits; callers keep only the low w bits.
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/decode_mac_pipe_if.sv
// Operand/result bundle for decode_mac_pipe.
// Handshake: valid-only, no back-pressure. When ce is high at a clk edge, a
// sample is accepted if in_valid is high at that edge; out_valid marks the
// edge at which dout was loaded with a new result. With ce low nothing moves,
// so out_valid/dout keep showing whatever they showed before the freeze.
interface decode_mac_pipe_if #(
  parameter int din0_WIDTH = 40,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 70
);
  logic                  ce;
  logic                  in_valid;
  logic [1:0]            op;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic [dout_WIDTH-1:0] dout;
  logic                  out_valid;
  logic                  ovf;
  logic [dout_WIDTH-1:0] acc;   // accumulator, exposed for observation

  modport master (
    output ce, in_valid, op, din0, din1,
    input  dout, out_valid, ovf, acc
  );

  modport slave (
    input  ce, in_valid, op, din0, din1,
    output dout, out_valid, ovf, acc
  );
endinterface

// File: rtl/decode_mul_pipe.sv
// Multiplier with a NUM_STAGE-1 deep delay line behind it. The product is
// formed exactly, then sign-extended or truncated (LSBs kept) to dout_WIDTH.
module decode_mul_pipe #(
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 40,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 70,
  parameter int A_SIGNED   = 1,
  parameter int B_SIGNED   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] prod
);

  // One spare bit so an unsigned x unsigned product is still exact as signed.
  localparam int FW = din0_WIDTH + din1_WIDTH + 1;

  logic signed [FW-1:0]  a_ext;
  logic signed [FW-1:0]  b_ext;
  logic signed [FW-1:0]  full;
  logic [dout_WIDTH-1:0] prod_c;

  // Extend each operand according to its own signedness, then multiply.
  always_comb begin
    if (A_SIGNED != 0) a_ext = FW'($signed(din0));
    else               a_ext = FW'($unsigned(din0));
    if (B_SIGNED != 0) b_ext = FW'($signed(din1));
    else               b_ext = FW'($unsigned(din1));
    full   = a_ext * b_ext;
    prod_c = dout_WIDTH'(full);
  end

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign prod = prod_c;
    end else begin : g_pipe
      logic [dout_WIDTH-1:0] pipe_q [NUM_STAGE-1];

      // Delay line: cleared by reset, shifts only while ce is high.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) pipe_q[i] <= '0;
        end else if (ce) begin
          pipe_q[0] <= prod_c;
          for (int i = 1; i < NUM_STAGE - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign prod = pipe_q[NUM_STAGE-2];
    end
  endgenerate

endmodule

// File: rtl/decode_mac_pipe.sv
// Pipelined multiply / multiply-accumulate. The product and a valid/op tag
// travel side by side; the last stage either forwards the product (MUL),
// adds it into the accumulator (MAC) or replaces the accumulator (LOAD).
module decode_mac_pipe
  import decode_mac_pkg::*;
#(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 40,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 70,
  parameter int A_SIGNED   = 1,
  parameter int B_SIGNED   = 1,
  parameter int SAT        = 0
) (
  input logic              clk,
  input logic              reset,
  decode_mac_pipe_if.slave bus
);

  // ID is only a tag; it is merely required to be non-negative.
  generate
    if (NUM_STAGE < 1 || NUM_STAGE > 8 || dout_WIDTH < 2 ||
        dout_WIDTH > MAX_W || ID < 0) begin : g_bad_param
      $error("decode_mac_pipe: illegal NUM_STAGE/dout_WIDTH/ID");
    end
  endgenerate

  localparam logic [dout_WIDTH-1:0] SAT_MAX = dout_WIDTH'(sat_max(dout_WIDTH));
  localparam logic [dout_WIDTH-1:0] SAT_MIN = dout_WIDTH'(sat_min(dout_WIDTH));

  logic [dout_WIDTH-1:0] prod;
  tag_t                  tag_in;
  tag_t                  tag_acc;

  logic [dout_WIDTH-1:0] acc_q;
  logic [dout_WIDTH-1:0] dout_q;
  logic                  ovf_q;
  logic                  out_valid_q;

  logic [dout_WIDTH:0]   sum_w;
  logic                  mac_ovf;
  logic [dout_WIDTH-1:0] mac_res;

  decode_mul_pipe #(
    .NUM_STAGE  (NUM_STAGE),
    .din0_WIDTH (din0_WIDTH),
    .din1_WIDTH (din1_WIDTH),
    .dout_WIDTH (dout_WIDTH),
    .A_SIGNED   (A_SIGNED),
    .B_SIGNED   (B_SIGNED)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (bus.ce),
    .din0  (bus.din0),
    .din1  (bus.din1),
    .prod  (prod)
  );

  assign tag_in = '{valid: bus.in_valid, op: op_e'(bus.op)};

  generate
    if (NUM_STAGE == 1) begin : g_tag_comb
      assign tag_acc = tag_in;
    end else begin : g_tag_pipe
      tag_t tag_q [NUM_STAGE-1];

      // Tag delay line, kept in lock-step with the product delay line.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) tag_q[i] <= '{valid: 1'b0, op: OP_MUL};
        end else if (bus.ce) begin
          tag_q[0] <= tag_in;
          for (int i = 1; i < NUM_STAGE - 1; i++) tag_q[i] <= tag_q[i-1];
        end
      end

      assign tag_acc = tag_q[NUM_STAGE-2];
    end
  endgenerate

  // Signed add with one guard bit; overflow when the top two bits disagree.
  always_comb begin
    sum_w   = {acc_q[dout_WIDTH-1], acc_q} + {prod[dout_WIDTH-1], prod};
    mac_ovf = sum_w[dout_WIDTH] ^ sum_w[dout_WIDTH-1];
    mac_res = sum_w[dout_WIDTH-1:0];
    if (mac_ovf && (SAT != 0)) mac_res = sum_w[dout_WIDTH] ? SAT_MIN : SAT_MAX;
  end

  // Accumulate/output stage; acc feeds straight back so MACs chain every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.ce) begin
      out_valid_q <= tag_acc.valid;
      if (tag_acc.valid) begin
        case (tag_acc.op)
          OP_MAC: begin
            acc_q  <= mac_res;
            dout_q <= mac_res;
            if (mac_ovf) ovf_q <= 1'b1;
          end
          OP_LOAD: begin
            acc_q  <= prod;
            dout_q <= prod;
            ovf_q  <= 1'b0;
          end
          default: dout_q <= prod;
        endcase
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf       = ovf_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_decode_mac_pipe.sv
// Bench for decode_mac_pipe: a wide signed wrapping instance checked cycle by
// cycle against a queue-based reference model, plus three small instances
// (8-bit saturating, 8-bit wrapping, unsigned x signed) for the edge cases.
module tb_decode_mac_pipe;
  import decode_mac_pkg::*;

  localparam int NS = 3;
  localparam int AW = 40;
  localparam int BW = 32;
  localparam int DW = 70;
  localparam logic signed [127:0] MAXV = (128'sd1 <<< (DW - 1)) - 128'sd1;
  localparam logic signed [127:0] MINV = -MAXV - 128'sd1;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_mac_pipe_if #(.din0_WIDTH(AW), .din1_WIDTH(BW), .dout_WIDTH(DW)) m_if ();
  decode_mac_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8))   s1_if ();
  decode_mac_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8))   s0_if ();
  decode_mac_pipe_if #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16))  u_if ();

  decode_mac_pipe #(.ID(1), .NUM_STAGE(NS), .din0_WIDTH(AW), .din1_WIDTH(BW), .dout_WIDTH(DW),
                    .A_SIGNED(1), .B_SIGNED(1), .SAT(0))
    dut (.clk(clk), .reset(reset), .bus(m_if));
  decode_mac_pipe #(.ID(2), .NUM_STAGE(NS), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
                    .A_SIGNED(1), .B_SIGNED(1), .SAT(1))
    dut_sat1 (.clk(clk), .reset(reset), .bus(s1_if));
  decode_mac_pipe #(.ID(3), .NUM_STAGE(NS), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(8),
                    .A_SIGNED(1), .B_SIGNED(1), .SAT(0))
    dut_sat0 (.clk(clk), .reset(reset), .bus(s0_if));
  decode_mac_pipe #(.ID(4), .NUM_STAGE(NS), .din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
                    .A_SIGNED(0), .B_SIGNED(1), .SAT(0))
    dut_uns (.clk(clk), .reset(reset), .bus(u_if));

  // Small instances share one set of stimulus variables.
  logic       s_ce, s_vld;
  logic [1:0] s_op;
  logic [7:0] s_a, s_b;
  assign s1_if.ce = s_ce;  assign s1_if.in_valid = s_vld;  assign s1_if.op = s_op;
  assign s1_if.din0 = s_a; assign s1_if.din1 = s_b;
  assign s0_if.ce = s_ce;  assign s0_if.in_valid = s_vld;  assign s0_if.op = s_op;
  assign s0_if.din0 = s_a; assign s0_if.din1 = s_b;
  assign u_if.ce = s_ce;   assign u_if.in_valid = s_vld;   assign u_if.op = s_op;
  assign u_if.din0 = s_a;  assign u_if.din1 = s_b;

  // ---------------- reference model ----------------
  // Each accepted sample is stamped with the ce-count at which it must appear.
  typedef struct {
    logic [1:0]             op;
    logic signed [DW-1:0]   p;
    int                     due;
  } item_t;

  item_t                pend[$];
  int                   ce_count = 0;
  logic                 m_valid = 1'b0;
  logic                 m_ovf   = 1'b0;
  logic signed [DW-1:0] m_dout  = '0;
  logic signed [DW-1:0] m_acc   = '0;

  function automatic logic signed [DW-1:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [127:0] fa;
    logic signed [127:0] fb;
    fa = 128'($signed(a));
    fb = 128'($signed(b));
    return DW'(fa * fb);
  endfunction

  task automatic model_edge(input logic rst, input logic c, input logic v,
                            input logic [1:0] o, input logic signed [DW-1:0] p);
    item_t               it;
    logic signed [127:0] s;
    if (rst) begin
      pend.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_dout = '0; m_acc = '0;
      return;
    end
    if (!c) return;
    ce_count++;
    if (v) pend.push_back('{op: o, p: p, due: ce_count - 1 + NS});
    m_valid = 1'b0;
    if (pend.size() != 0 && pend[0].due == ce_count) begin
      it = pend.pop_front();
      m_valid = 1'b1;
      case (it.op)
        2'b01: begin
          s = 128'(m_acc) + 128'(it.p);
          if (s > MAXV || s < MINV) m_ovf = 1'b1;
          m_acc  = DW'(s);
          m_dout = m_acc;
        end
        2'b10: begin
          m_acc  = it.p;
          m_dout = it.p;
          m_ovf  = 1'b0;
        end
        default: m_dout = it.p;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive at the falling edge, update the model for the coming
  // rising edge, then settle 1 time unit past it before anyone samples.
  task automatic tick(input logic rst, input logic c, input logic v, input logic [1:0] o,
                      input logic [AW-1:0] a, input logic [BW-1:0] b);
    @(negedge clk);
    reset = rst;
    m_if.ce = c; m_if.in_valid = v; m_if.op = o; m_if.din0 = a; m_if.din1 = b;
    model_edge(rst, c, v, o, ref_prod(a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b1, 1'b0, OP_MUL, '0, '0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(1'b1, 1'b0, 1'b0, OP_MUL, '0, '0);
    tick(1'b1, 1'b0, 1'b1, OP_MAC, AW'(3), BW'(4));
    total++;
    if ({m_if.out_valid, m_if.ovf, m_if.dout, m_if.acc} !== {1'b0, 1'b0, {DW{1'b0}}, {DW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_main got v=%b ovf=%b dout=%0d acc=%0d need all 0",
               m_if.out_valid, m_if.ovf, m_if.dout, m_if.acc);
    end
    total++;
    if ({s1_if.out_valid, s1_if.ovf, s1_if.dout, s0_if.out_valid, s0_if.ovf, s0_if.dout,
         u_if.out_valid, u_if.dout} !== 37'd0) begin
      bad++;
      $display("FAIL reset_small got s1=%b/%b/%h s0=%b/%b/%h u=%b/%h need all 0",
               s1_if.out_valid, s1_if.ovf, s1_if.dout, s0_if.out_valid, s0_if.ovf, s0_if.dout,
               u_if.out_valid, u_if.dout);
    end
  endtask

  task automatic test_mul_latency();
    logic [DW-1:0] acc_before;
    acc_before = m_if.acc;
    tick(1'b0, 1'b1, 1'b1, OP_MUL, AW'(-5), BW'(7));
    for (int i = 1; i < NS; i++) begin
      total++;
      if (m_if.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mul_early_valid edge=%0d got out_valid=%b need 0", i, m_if.out_valid);
      end
      idle();
    end
    total++;
    if (m_if.out_valid !== 1'b1 || m_if.dout !== DW'(-35) || m_if.acc !== acc_before) begin
      bad++;
      $display("FAIL mul_latency got v=%b dout=%0d acc=%0d need v=1 dout=-35 acc=%0d",
               m_if.out_valid, $signed(m_if.dout), $signed(m_if.acc), $signed(acc_before));
    end
  endtask

  task automatic test_load_mac();
    logic [DW-1:0] exp_q[$];
    exp_q = '{DW'(6), DW'(26), DW'(16)};
    tick(1'b0, 1'b1, 1'b1, OP_LOAD, AW'(2), BW'(3));
    tick(1'b0, 1'b1, 1'b1, OP_MAC, AW'(4), BW'(5));
    tick(1'b0, 1'b1, 1'b1, OP_MAC, AW'(-1), BW'(10));
    for (int i = 0; i < NS + 1; i++) begin
      if (m_if.out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL load_mac_extra got dout=%0d need no further result", $signed(m_if.dout));
        end else if (m_if.dout !== exp_q[0] || m_if.ovf !== 1'b0) begin
          bad++;
          $display("FAIL load_mac_seq got dout=%0d ovf=%b need dout=%0d ovf=0",
                   $signed(m_if.dout), m_if.ovf, $signed(exp_q[0]));
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      idle();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL load_mac_missing got %0d results left need 0", exp_q.size());
    end
  endtask

  task automatic test_reset_in_flight();
    tick(1'b0, 1'b1, 1'b1, OP_LOAD, AW'(9), BW'(9));
    tick(1'b0, 1'b1, 1'b1, OP_MAC, AW'(3), BW'(3));
    tick(1'b1, 1'b1, 1'b0, OP_MUL, '0, '0);
    for (int i = 0; i < NS; i++) begin
      idle();
      total++;
      if (m_if.out_valid !== 1'b0 || m_if.dout !== '0 || m_if.acc !== '0 || m_if.ovf !== 1'b0) begin
        bad++;
        $display("FAIL reset_flight edge=%0d got v=%b dout=%0d acc=%0d ovf=%b need 0/0/0/0",
                 i, m_if.out_valid, $signed(m_if.dout), $signed(m_if.acc), m_if.ovf);
      end
    end
  endtask

  task automatic test_ce_freeze();
    int n_in  = 0;
    int n_out = 0;
    logic c, v;
    for (int i = 0; i < 16 + NS; i++) begin
      c = !(i >= 5 && i < 9);
      v = (i < 14) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if (c && v) n_in++;
      tick(1'b0, c, v, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 200)) - AW'(100),
           BW'($urandom_range(0, 60)) - BW'(30));
      if (c && m_if.out_valid === 1'b1) n_out++;
      total++;
      if ({m_if.out_valid, m_if.ovf, m_if.dout, m_if.acc} !== {m_valid, m_ovf, m_dout, m_acc}) begin
        bad++;
        $display("FAIL ce_freeze step=%0d got v=%b ovf=%b dout=%0d acc=%0d need v=%b ovf=%b dout=%0d acc=%0d",
                 i, m_if.out_valid, m_if.ovf, $signed(m_if.dout), $signed(m_if.acc),
                 m_valid, m_ovf, m_dout, m_acc);
      end
    end
    total++;
    if (n_out != n_in) begin
      bad++;
      $display("FAIL ce_freeze_count got %0d results need %0d", n_out, n_in);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q[$];
    longint        sum;
    longint        a, b;
    sum = 7;
    exp_q.push_back(DW'(sum));
    tick(1'b0, 1'b1, 1'b1, OP_LOAD, AW'(7), BW'(1));
    for (int i = 0; i < 8; i++) begin
      a = longint'($urandom_range(0, 2000)) - 1000;
      b = longint'($urandom_range(0, 2000)) - 1000;
      sum = sum + a * b;
      exp_q.push_back(DW'(sum));
      tick(1'b0, 1'b1, 1'b1, OP_MAC, AW'(a), BW'(b));
      if (m_if.out_valid === 1'b1) begin
        total++;
        if (m_if.dout !== exp_q[0]) begin
          bad++;
          $display("FAIL b2b_mac got dout=%0d need %0d", $signed(m_if.dout), $signed(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
    end
    for (int i = 0; i < NS + 1; i++) begin
      idle();
      if (m_if.out_valid === 1'b1 && exp_q.size() != 0) begin
        total++;
        if (m_if.dout !== exp_q[0] || m_if.acc !== exp_q[0]) begin
          bad++;
          $display("FAIL b2b_mac got dout=%0d acc=%0d need %0d",
                   $signed(m_if.dout), $signed(m_if.acc), $signed(exp_q[0]));
        end
        void'(exp_q.pop_front());
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing got %0d results left need 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = AW'({$urandom(), $urandom()}); b = BW'($urandom()); end
        1: begin a = {1'b0, {(AW-1){1'b1}}}; b = ($urandom_range(0, 1) != 0) ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}}; end
        default: begin a = AW'($urandom_range(0, 100)) - AW'(50); b = BW'($urandom_range(0, 100)) - BW'(50); end
      endcase
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
           2'($urandom_range(0, 3)), a, b);
      total++;
      if ({m_if.out_valid, m_if.ovf, m_if.dout, m_if.acc} !== {m_valid, m_ovf, m_dout, m_acc}) begin
        bad++;
        $display("FAIL random step=%0d got v=%b ovf=%b dout=%h acc=%h need v=%b ovf=%b dout=%h acc=%h",
                 i, m_if.out_valid, m_if.ovf, m_if.dout, m_if.acc, m_valid, m_ovf, m_dout, m_acc);
      end
    end
  endtask

  task automatic test_sat();
    s_ce = 1'b1;
    s_vld = 1'b1; s_op = OP_LOAD; s_a = 8'd100; s_b = 8'd1;
    idle();
    s_op = OP_MAC; s_a = 8'd10; s_b = 8'd10;
    idle();
    s_vld = 1'b0;
    idle();
    idle();
    total++;
    if (s1_if.out_valid !== 1'b1 || s1_if.dout !== 8'd127 || s1_if.ovf !== 1'b1 || s1_if.acc !== 8'd127) begin
      bad++;
      $display("FAIL sat_clamp got v=%b dout=%0d acc=%0d ovf=%b need v=1 dout=127 acc=127 ovf=1",
               s1_if.out_valid, $signed(s1_if.dout), $signed(s1_if.acc), s1_if.ovf);
    end
    total++;
    if (s0_if.out_valid !== 1'b1 || s0_if.dout !== 8'hC8 || s0_if.ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_wrap got v=%b dout=%0d ovf=%b need v=1 dout=-56 ovf=1",
               s0_if.out_valid, $signed(s0_if.dout), s0_if.ovf);
    end
    s_vld = 1'b1; s_op = OP_LOAD; s_a = 8'd5; s_b = 8'd1;
    idle();
    s_vld = 1'b0;
    idle();
    idle();
    total++;
    if (s1_if.ovf !== 1'b0 || s0_if.ovf !== 1'b0 || s1_if.dout !== 8'd5 || s0_if.acc !== 8'd5) begin
      bad++;
      $display("FAIL load_clears_ovf got ovf1=%b ovf0=%b dout1=%0d acc0=%0d need 0 0 5 5",
               s1_if.ovf, s0_if.ovf, s1_if.dout, s0_if.acc);
    end
  endtask

  task automatic test_unsigned();
    s_ce = 1'b1;
    s_vld = 1'b1; s_op = OP_MUL; s_a = 8'hFF; s_b = 8'hFF;
    idle();
    s_vld = 1'b0;
    idle();
    idle();
    total++;
    if (u_if.out_valid !== 1'b1 || u_if.dout !== 16'hFF01) begin
      bad++;
      $display("FAIL unsigned_x_signed got v=%b dout=%0d need v=1 dout=-255",
               u_if.out_valid, $signed(u_if.dout));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    m_if.ce = 1'b0; m_if.in_valid = 1'b0; m_if.op = 2'b00; m_if.din0 = '0; m_if.din1 = '0;
    s_ce = 1'b0; s_vld = 1'b0; s_op = 2'b00; s_a = '0; s_b = '0;
    test_reset();
    test_mul_latency();
    test_load_mac();
    test_reset_in_flight();
    test_ce_freeze();
    test_back_to_back();
    test_random();
    test_sat();
    test_unsigned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1, "watchdog");
  end

endmodule
